alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//   ID/EX pipeline stage directly upstream of the ALU. Selects each ALU operand from
//   register-file data, PC or immediate, and forwards results from EX/MEM and MEM/WB.
//   Registers the selected operands and the ALU select for one cycle, with stall and flush.
//   DataA/DataB/ALUSel connect 1:1 to the ALU ports of the same names.
// PARAMETERS
//   WIDTH_DATA_LENGTH    32  operand/data width
//   WIDTH_ALUSEL_LENGTH  4   ALU select width
//   WIDTH_REG_ADDR       5   register index width (x0..x31)
// PORTS
//   clk          in   1     clock; all state updates on rising edge
//   rst          in   1     asynchronous, active-high reset
//   InValid      in   1     decode stage presents a valid instruction
//   InReady      out  1     stage can accept this cycle (= ~Stall)
//   Stall        in   1     hazard unit: hold stage contents
//   Flush        in   1     branch/jump redirect: kill the captured instruction
//   PC           in   W     PC of decoded instruction
//   RS1Data      in   W     regfile read port 1
//   RS2Data      in   W     regfile read port 2
//   Imm          in   W     sign-extended immediate
//   RS1Addr      in   5     source register 1 index
//   RS2Addr      in   5     source register 2 index
//   RdAddr       in   5     destination index
//   RegWEn       in   1     instruction writes Rd
//   ASel         in   1     0: A = rs1 (fwd), 1: A = PC
//   BSel         in   1     0: B = rs2 (fwd), 1: B = Imm
//   ALUSelIn     in   4     ALU operation from decoder
//   ExMemRegWEn  in   1     EX/MEM instruction writes a register
//   ExMemRd      in   5     EX/MEM destination
//   ExMemData    in   W     EX/MEM ALU result
//   MemWbRegWEn  in   1     MEM/WB instruction writes a register
//   MemWbRd      in   5     MEM/WB destination
//   MemWbData    in   W     MEM/WB write-back value
//   DataA        out  W     registered ALU operand A
//   DataB        out  W     registered ALU operand B
//   ALUSel       out  4     registered ALU select
//   StoreData    out  W     registered forwarded rs2 (store data, independent of BSel)
//   RdAddrOut    out  5     registered destination
//   RegWEnOut    out  1     registered write enable; 0 whenever OutValid = 0
//   OutValid     out  1     registered valid for the EX stage
// BEHAVIOUR
//   Reset (async, rst=1): all outputs 0 immediately; ALUSel = 4'b0000 (ADD); OutValid = 0.
//   Forwarding (combinational, per source rsN):
//     - EX/MEM match if ExMemRegWEn && ExMemRd==rsN && rsN!=0 -> ExMemData
//     - else MEM/WB match if MemWbRegWEn && MemWbRd==rsN && rsN!=0 -> MemWbData
//     - else RSnData. EX/MEM has priority when both match. x0 is never forwarded.
//   Operand mux: A = ASel ? PC : fwd_rs1; B = BSel ? Imm : fwd_rs2; StoreData = fwd_rs2.
//   Latency: 1 cycle from capture edge to DataA/DataB/ALUSel; no combinational in->out path.
//   Per rising edge, in priority order:
//     1. Flush=1: OutValid<=0, RegWEnOut<=0, data/select/Rd outputs <= 0 (bubble).
//        Flush overrides Stall.
//     2. Stall=1: all output registers hold. Upstream keeps its inputs stable.
//     3. Else: capture muxed values; OutValid<=InValid; RegWEnOut<=RegWEn&InValid.
//        When InValid=0, data outputs <= 0 and ALUSel <= 0.
//   InReady = ~Stall (combinational). Flush with Stall=0 still accepts nothing:
//   the captured slot is a bubble.
//   Width: all data paths W bits, no extension or truncation; RdAddrOut carries x0 as-is.
//   Reset mid-operation: pending contents discarded. The first capture after rst falls
//   follows rule 3.
// TESTING
//   1. Reset: rst=1 mid-stream -> all outputs 0 asynchronously; OutValid=0 until next valid capture.
//   2. Plain ADD: RS1Data=100, RS2Data=456, ASel=BSel=0, ALUSelIn=0, no fwd -> next cycle
//      DataA=100, DataB=456, OutValid=1; ALU DataOut=556.
//   3. Forward priority: RS1Addr=5, ExMemRd=5 (data 32'hAAAA), MemWbRd=5 (data 32'hBBBB),
//      both RegWEn=1 -> DataA=32'hAAAA. Repeat with ExMemRegWEn=0 -> DataA=32'hBBBB.
//   4. x0 guard: RS2Addr=0, ExMemRd=0, ExMemRegWEn=1, ExMemData=7, RS2Data=0 -> DataB=0, StoreData=0.
//   5. Stall/flush: capture DataA=-100, then Stall=1 for 3 cycles with new inputs -> outputs hold -100.
//      Then Flush=1 with Stall=1 -> OutValid=0, RegWEnOut=0, DataA=0.
//   6. Imm/PC select: PC=32'h100, Imm=-1235, ASel=1, BSel=1 -> DataA=32'h100, DataB=-32'd1235,
//      StoreData = forwarded rs2.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX stage with forwarding and operand select. In: decode/regfile/forwarding buses and Stall/Flush. Out: registered DataA/DataB/ALUSel/StoreData/RdAddrOut/RegWEnOut/OutValid.
module alu_operand_stage #(
  parameter int WIDTH_DATA_LENGTH   = 32,
  parameter int WIDTH_ALUSEL_LENGTH = 4,
  parameter int WIDTH_REG_ADDR      = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           InValid,
  output logic                           InReady,
  input  logic                           Stall,
  input  logic                           Flush,
  input  logic [WIDTH_DATA_LENGTH-1:0]   PC,
  input  logic [WIDTH_DATA_LENGTH-1:0]   RS1Data,
  input  logic [WIDTH_DATA_LENGTH-1:0]   RS2Data,
  input  logic [WIDTH_DATA_LENGTH-1:0]   Imm,
  input  logic [WIDTH_REG_ADDR-1:0]      RS1Addr,
  input  logic [WIDTH_REG_ADDR-1:0]      RS2Addr,
  input  logic [WIDTH_REG_ADDR-1:0]      RdAddr,
  input  logic                           RegWEn,
  input  logic                           ASel,
  input  logic                           BSel,
  input  logic [WIDTH_ALUSEL_LENGTH-1:0] ALUSelIn,
  input  logic                           ExMemRegWEn,
  input  logic [WIDTH_REG_ADDR-1:0]      ExMemRd,
  input  logic [WIDTH_DATA_LENGTH-1:0]   ExMemData,
  input  logic                           MemWbRegWEn,
  input  logic [WIDTH_REG_ADDR-1:0]      MemWbRd,
  input  logic [WIDTH_DATA_LENGTH-1:0]   MemWbData,
  output logic [WIDTH_DATA_LENGTH-1:0]   DataA,
  output logic [WIDTH_DATA_LENGTH-1:0]   DataB,
  output logic [WIDTH_ALUSEL_LENGTH-1:0] ALUSel,
  output logic [WIDTH_DATA_LENGTH-1:0]   StoreData,
  output logic [WIDTH_REG_ADDR-1:0]      RdAddrOut,
  output logic                           RegWEnOut,
  output logic                           OutValid
);
  logic [WIDTH_DATA_LENGTH-1:0] fwd_a, fwd_b;
  logic kill;
  always_comb begin
    fwd_a = (ExMemRegWEn && ExMemRd == RS1Addr && RS1Addr != '0) ? ExMemData :
            (MemWbRegWEn && MemWbRd == RS1Addr && RS1Addr != '0) ? MemWbData : RS1Data;
    fwd_b = (ExMemRegWEn && ExMemRd == RS2Addr && RS2Addr != '0) ? ExMemData :
            (MemWbRegWEn && MemWbRd == RS2Addr && RS2Addr != '0) ? MemWbData : RS2Data;
    kill  = Flush || !InValid;
  end
  assign InReady = ~Stall;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DataA     <= '0;
      DataB     <= '0;
      ALUSel    <= '0;
      StoreData <= '0;
      RdAddrOut <= '0;
      RegWEnOut <= 1'b0;
      OutValid  <= 1'b0;
    end else if (Flush || !Stall) begin
      DataA     <= kill ? '0 : (ASel ? PC : fwd_a);
      DataB     <= kill ? '0 : (BSel ? Imm : fwd_b);
      ALUSel    <= kill ? '0 : ALUSelIn;
      StoreData <= kill ? '0 : fwd_b;
      RdAddrOut <= kill ? '0 : RdAddr;
      RegWEnOut <= !kill && RegWEn;
      OutValid  <= !kill;
    end
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed vectors with a queue scoreboard checked by an independent monitor.
module tb_alu_operand_stage;
  logic clk, rst, InValid, InReady, Stall, Flush, RegWEn, ASel, BSel;
  logic ExMemRegWEn, MemWbRegWEn, RegWEnOut, OutValid;
  logic [31:0] PC, RS1Data, RS2Data, Imm, ExMemData, MemWbData, DataA, DataB, StoreData;
  logic [4:0] RS1Addr, RS2Addr, RdAddr, ExMemRd, MemWbRd, RdAddrOut;
  logic [3:0] ALUSelIn, ALUSel;
  typedef struct packed {
    logic v;
    logic we;
    logic [4:0] rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0] sel;
    logic [31:0] st;
  } exp_t;
  exp_t q[$];
  int tq[$];
  int checks = 0, errors = 0, tag = 0;
  alu_operand_stage dut (
    .clk(clk), .rst(rst), .InValid(InValid), .InReady(InReady), .Stall(Stall), .Flush(Flush),
    .PC(PC), .RS1Data(RS1Data), .RS2Data(RS2Data), .Imm(Imm), .RS1Addr(RS1Addr),
    .RS2Addr(RS2Addr), .RdAddr(RdAddr), .RegWEn(RegWEn), .ASel(ASel), .BSel(BSel),
    .ALUSelIn(ALUSelIn), .ExMemRegWEn(ExMemRegWEn), .ExMemRd(ExMemRd), .ExMemData(ExMemData),
    .MemWbRegWEn(MemWbRegWEn), .MemWbRd(MemWbRd), .MemWbData(MemWbData), .DataA(DataA),
    .DataB(DataB), .ALUSel(ALUSel), .StoreData(StoreData), .RdAddrOut(RdAddrOut),
    .RegWEnOut(RegWEnOut), .OutValid(OutValid)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic idle();
    {InValid, Stall, Flush, RegWEn, ASel, BSel, ExMemRegWEn, MemWbRegWEn} = '0;
    {PC, RS1Data, RS2Data, Imm, ExMemData, MemWbData} = '0;
    {RS1Addr, RS2Addr, RdAddr, ExMemRd, MemWbRd} = '0;
    ALUSelIn = '0;
  endtask
  task automatic chk_zero(input string nm);
    checks++;
    if ({OutValid, RegWEnOut, RdAddrOut, DataA, DataB, ALUSel, StoreData} !== '0) begin
      errors++;
      $display("FAIL %s act v=%b we=%b rd=%0d a=%h b=%h sel=%h st=%h exp all zero", nm,
               OutValid, RegWEnOut, RdAddrOut, DataA, DataB, ALUSel, StoreData);
    end
  endtask
  task automatic go(input logic v, input logic we, input logic [4:0] rd, input logic [31:0] a,
                    input logic [31:0] b, input logic [3:0] sel, input logic [31:0] st);
    #1;
    checks++;
    if (InReady !== !Stall) begin
      errors++;
      $display("FAIL inready%0d act=%b exp=%b", tag, InReady, !Stall);
    end
    q.push_back('{v: v, we: we, rd: rd, a: a, b: b, sel: sel, st: st});
    tq.push_back(tag++);
    @(negedge clk);
  endtask
  initial begin
    exp_t e, act;
    int t;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        t = tq.pop_front();
        act = '{v: OutValid, we: RegWEnOut, rd: e.v ? RdAddrOut : 5'd0, a: DataA, b: DataB,
                sel: ALUSel, st: StoreData};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL vec%0d act v=%b we=%b rd=%0d a=%h b=%h sel=%h st=%h exp v=%b we=%b rd=%0d a=%h b=%h sel=%h st=%h",
                   t, act.v, act.we, act.rd, act.a, act.b, act.sel, act.st,
                   e.v, e.we, e.rd, e.a, e.b, e.sel, e.st);
        end
      end
    end
  end
  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    idle(); InValid = 1; RS1Data = 100; RS2Data = 456; RS1Addr = 1; RS2Addr = 2; RdAddr = 3; RegWEn = 1;
    go(1, 1, 3, 100, 456, 0, 456);
    idle(); InValid = 1; RS1Addr = 5; RS1Data = 1; RS2Addr = 6; RS2Data = 2; RdAddr = 4; ALUSelIn = 4'h7;
    ExMemRegWEn = 1; ExMemRd = 5; ExMemData = 32'hAAAA; MemWbRegWEn = 1; MemWbRd = 5; MemWbData = 32'hBBBB;
    go(1, 0, 4, 32'hAAAA, 2, 4'h7, 2);
    ExMemRegWEn = 0;
    go(1, 0, 4, 32'hBBBB, 2, 4'h7, 2);
    idle(); InValid = 1; RegWEn = 1; ExMemRegWEn = 1; ExMemData = 7; MemWbRegWEn = 1; MemWbData = 9;
    go(1, 1, 0, 0, 0, 0, 0);
    idle(); InValid = 1; PC = 32'h100; Imm = -32'd1235; ASel = 1; BSel = 1; RS1Addr = 9; RS2Addr = 8;
    RS2Data = 3; MemWbRegWEn = 1; MemWbRd = 8; MemWbData = 32'h1234; ExMemRegWEn = 1; ExMemRd = 9;
    ExMemData = 5; ALUSelIn = 4'h3; RdAddr = 10; RegWEn = 1;
    go(1, 1, 10, 32'h100, -32'd1235, 4'h3, 32'h1234);
    idle(); InValid = 1; RS1Addr = 3; RS1Data = -32'd100; RS2Addr = 4; RS2Data = 10; ALUSelIn = 1;
    RdAddr = 7; RegWEn = 1;
    go(1, 1, 7, -32'd100, 10, 1, 10);
    for (int i = 0; i < 3; i++) begin
      idle(); Stall = 1; InValid = 1; RS1Data = 55 + i; RS2Data = 66; ALUSelIn = 2; RdAddr = 12;
      go(1, 1, 7, -32'd100, 10, 1, 10);
    end
    Flush = 1;
    go(0, 0, 0, 0, 0, 0, 0);
    idle(); RS1Data = 77; RS2Data = 78; RegWEn = 1; ALUSelIn = 5; RdAddr = 2;
    go(0, 0, 0, 0, 0, 0, 0);
    idle(); InValid = 1; Flush = 1; RS1Data = 11; RegWEn = 1; RdAddr = 2;
    go(0, 0, 0, 0, 0, 0, 0);
    idle(); InValid = 1; RS1Data = 1; RS2Data = 2; ALUSelIn = 2; RdAddr = 31; RegWEn = 1;
    go(1, 1, 31, 1, 2, 2, 2);
    rst = 1'b1;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    chk_zero("reset_held");
    rst = 1'b0;
    idle(); RS1Data = 44;
    go(0, 0, 0, 0, 0, 0, 0);
    idle(); InValid = 1; RS1Data = 21; RS2Data = 22; ALUSelIn = 4'hF; RdAddr = 6; RegWEn = 1;
    go(1, 1, 6, 21, 22, 4'hF, 22);
    idle();
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain act=%0d exp=0 pending", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
